// File: rtl/aes_pkg.sv
// Shared AES types and the ShiftRows byte permutation tables.
package aes_pkg;

   typedef logic [7:0] aes_byte_t;
   typedef logic [3:0] aes_idx_t;

   // Source index for output byte k = 4*c + r, forward: in[r][(c+r) mod 4]
   localparam aes_idx_t SR_FWD_MAP [16] = '{
      4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
      4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11
   };

   // Source index for output byte k = 4*c + r, inverse: in[r][(c-r) mod 4]
   localparam aes_idx_t SR_INV_MAP [16] = '{
      4'd0, 4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11,
      4'd8, 4'd5, 4'd2, 4'd15, 4'd12, 4'd9, 4'd6, 4'd3
   };

   function automatic aes_idx_t sr_map(input aes_idx_t idx, input logic inverse);
      if (inverse) begin
         return SR_INV_MAP[idx];
      end
      return SR_FWD_MAP[idx];
   endfunction

endpackage

// File: rtl/inv_shiftrow_stream.sv
// Byte-serial (Inv)ShiftRows with a two-bank ping-pong buffer: one bank fills
// in natural byte order while the other drains through the permutation map.
module inv_shiftrow_stream
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic       m_last
);

   aes_byte_t  bank_q [2][16];
   aes_byte_t  bank_d [2][16];
   logic       wsel_q, wsel_d;
   logic       rsel_q, rsel_d;
   aes_idx_t   wcnt_q, wcnt_d;
   aes_idx_t   rcnt_q, rcnt_d;
   logic [1:0] full_q, full_d;
   logic       wr_fire, rd_fire;
   aes_idx_t   rd_idx;

   // Handshakes and output mux; outputs depend only on registered state and rst.
   always_comb begin
      s_ready = !full_q[wsel_q] && !rst;
      m_valid = full_q[rsel_q] && !rst;
      rd_idx  = sr_map(rcnt_q, INVERSE);
      m_data  = m_valid ? bank_q[rsel_q][rd_idx] : 8'h00;
      m_last  = m_valid && (rcnt_q == 4'hF);
      wr_fire = s_valid && s_ready;
      rd_fire = m_valid && m_ready;
   end

   // Next-state: write pointer fills one bank, read pointer drains the other.
   always_comb begin
      bank_d = bank_q;
      wsel_d = wsel_q;
      rsel_d = rsel_q;
      wcnt_d = wcnt_q;
      rcnt_d = rcnt_q;
      full_d = full_q;
      if (wr_fire) begin
         bank_d[wsel_q][wcnt_q] = s_data;
         wcnt_d = wcnt_q + 4'd1;
         if (wcnt_q == 4'hF) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = !wsel_q;
         end
      end
      // Write bank is never full and read bank never filling, so these never collide.
      if (rd_fire) begin
         rcnt_d = rcnt_q + 4'd1;
         if (rcnt_q == 4'hF) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = !rsel_q;
         end
      end
   end

   // Control state register; reset drops every partial and full block.
   always_ff @(posedge clk) begin
      if (rst) begin
         wsel_q <= 1'b0;
         rsel_q <= 1'b0;
         wcnt_q <= 4'h0;
         rcnt_q <= 4'h0;
         full_q <= 2'b00;
      end else begin
         wsel_q <= wsel_d;
         rsel_q <= rsel_d;
         wcnt_q <= wcnt_d;
         rcnt_q <= rcnt_d;
         full_q <= full_d;
      end
   end

   // Byte storage, deliberately not reset.
   always_ff @(posedge clk) begin
      bank_q <= bank_d;
   end

endmodule

// File: tb/tb_inv_shiftrow_stream.sv
// Scoreboard bench: an inverse and a forward instance see the same stream.
module tb_inv_shiftrow_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       m_ready = 1'b0;
   logic       s_ready_i, m_valid_i, m_last_i;
   logic       s_ready_f, m_valid_f, m_last_f;
   logic [7:0] m_data_i, m_data_f;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   logic [8:0] exp_i[$];
   logic [8:0] exp_f[$];
   logic [7:0] log_i[$];
   logic [7:0] log_f[$];
   int         out_cyc[$];
   logic [7:0] cur_blk[$];
   bit         rdy_rand = 1'b0;
   bit         gap_rand = 1'b0;
   int         last_wait;
   int         last_acc_cyc;

   bit         hold_i = 1'b0, hold_f = 1'b0;
   logic [7:0] hd_i, hd_f;
   logic       hl_i, hl_f;

   logic [7:0] fips_in  [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
   logic [7:0] fips_out [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                 8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
   logic [7:0] idx_inv  [16] = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                                 8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
   logic [7:0] idx_fwd  [16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                                 8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

   inv_shiftrow_stream #(.INVERSE(1'b1)) u_inv (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_i), .s_data(s_data),
      .m_valid(m_valid_i), .m_ready(m_ready), .m_data(m_data_i), .m_last(m_last_i)
   );

   inv_shiftrow_stream #(.INVERSE(1'b0)) u_fwd (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_f), .s_data(s_data),
      .m_valid(m_valid_f), .m_ready(m_ready), .m_data(m_data_f), .m_last(m_last_f)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      if (rdy_rand) m_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Output byte k = 4*c + r takes in[r][(c -/+ r) mod 4].
   function automatic logic [7:0] model(input logic [7:0] blk[16], input int k, input bit inv);
      int c = k / 4;
      int r = k % 4;
      int sc = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
      return blk[4 * sc + r];
   endfunction

   task automatic record_byte(input logic [7:0] b);
      logic [7:0] blk[16];
      cur_blk.push_back(b);
      if (cur_blk.size() == 16) begin
         foreach (blk[i]) blk[i] = cur_blk[i];
         for (int k = 0; k < 16; k++) begin
            exp_i.push_back({(k == 15), model(blk, k, 1'b1)});
            exp_f.push_back({(k == 15), model(blk, k, 1'b0)});
         end
         cur_blk.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  n = 0;
      bit  ok = 1'b0;
      if (gap_rand) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
         end
      end
      s_valid = 1'b1;
      s_data  = b;
      while (!ok && n < 5000) begin
         @(negedge clk);
         ok = s_ready_i;
         last_acc_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      s_valid = 1'b0;
      last_wait = n;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      else record_byte(b);
   endtask

   task automatic wait_empty();
      int n = 0;
      while ((exp_i.size() != 0 || exp_f.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 5000) chk("drain_timeout", exp_i.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop expected byte on each output handshake, and check hold on stalls.
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst) begin
         hold_i = 1'b0;
         hold_f = 1'b0;
      end else begin
         if (hold_i) begin
            chk("hold_inv_valid", m_valid_i, 1'b1);
            chk("hold_inv_data", m_data_i, hd_i);
            chk("hold_inv_last", m_last_i, hl_i);
         end
         if (hold_f) begin
            chk("hold_fwd_data", m_data_f, hd_f);
         end
         if (m_valid_i && m_ready) begin
            if (exp_i.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL spurious_inv: got byte %0h, expected none", m_data_i);
            end else begin
               e = exp_i.pop_front();
               chk("inv_data", m_data_i, e[7:0]);
               chk("inv_last", m_last_i, e[8]);
            end
            log_i.push_back(m_data_i);
            out_cyc.push_back(cyc);
         end
         if (m_valid_f && m_ready) begin
            if (exp_f.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL spurious_fwd: got byte %0h, expected none", m_data_f);
            end else begin
               e = exp_f.pop_front();
               chk("fwd_data", m_data_f, e[7:0]);
               chk("fwd_last", m_last_f, e[8]);
            end
            log_f.push_back(m_data_f);
         end
         hold_i = m_valid_i && !m_ready;
         hd_i   = m_data_i;
         hl_i   = m_last_i;
         hold_f = m_valid_f && !m_ready;
         hd_f   = m_data_f;
      end
   end

   initial begin
      int acc;
      int outs;
      int first_acc;
      bit stalled;
      bit ok;

      // Reset state
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready_i, 1'b0);
      chk("rst_m_valid", m_valid_i, 1'b0);
      chk("rst_m_last", m_last_i, 1'b0);
      chk("rst_m_data", m_data_i, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", s_ready_i, 1'b1);
      chk("post_rst_m_valid", m_valid_i, 1'b0);
      @(posedge clk);
      #1;

      // 1: FIPS-197 InvShiftRows vector, first output the cycle after a15
      log_i.delete();
      for (int i = 0; i < 16; i++) send_byte(fips_in[i]);
      @(negedge clk);
      chk("fips_latency_valid", m_valid_i, 1'b1);
      chk("fips_first_byte", m_data_i, 8'hd4);
      wait_empty();
      chk("fips_count", log_i.size(), 32'd16);
      for (int i = 0; i < 16 && i < log_i.size(); i++) chk("fips_out", log_i[i], fips_out[i]);

      // 2: index pattern through both map directions
      log_i.delete();
      log_f.delete();
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      wait_empty();
      for (int i = 0; i < 16 && i < log_i.size(); i++) chk("idx_inv", log_i[i], idx_inv[i]);
      for (int i = 0; i < 16 && i < log_f.size(); i++) chk("idx_fwd", log_f[i], idx_fwd[i]);

      // 3: four back-to-back blocks, no bubbles
      out_cyc.delete();
      stalled = 1'b0;
      first_acc = 0;
      for (int i = 0; i < 64; i++) begin
         send_byte(8'($urandom));
         if (i == 0) first_acc = last_acc_cyc;
         if (last_wait != 1) stalled = 1'b1;
      end
      wait_empty();
      chk("stream_no_stall", stalled, 1'b0);
      chk("stream_count", out_cyc.size(), 32'd64);
      if (out_cyc.size() == 64) begin
         chk("stream_first_latency", out_cyc[0] - first_acc, 32'd16);
         chk("stream_contiguous", out_cyc[63] - out_cyc[0], 32'd63);
      end

      // 4: backpressure, 40 offers with m_ready low
      m_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         s_valid = 1'b1;
         s_data  = 8'h80 + 8'(acc);
         @(negedge clk);
         ok = s_ready_i;
         @(posedge clk);
         #1;
         if (ok) begin
            record_byte(s_data);
            acc++;
         end
      end
      s_valid = 1'b0;
      chk("bp_accepted", acc, 32'd32);
      @(negedge clk);
      chk("bp_s_ready_low", s_ready_i, 1'b0);
      chk("bp_m_valid", m_valid_i, 1'b1);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      outs = 0;
      for (int i = 0; i < 40 && outs < 16; i++) begin
         @(negedge clk);
         if (m_valid_i) outs++;
         if (outs == 16) chk("bp_s_ready_at_last", s_ready_i, 1'b0);
      end
      @(negedge clk);
      chk("bp_s_ready_after", s_ready_i, 1'b1);
      wait_empty();

      // 5: random handshakes, 1000 blocks
      rdy_rand = 1'b1;
      gap_rand = 1'b1;
      for (int i = 0; i < 16000; i++) send_byte(8'($urandom));
      wait_empty();
      rdy_rand = 1'b0;
      gap_rand = 1'b0;
      m_ready  = 1'b1;

      // 6: reset with one block half-drained and 7 bytes of the next
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i));
      for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i));
      m_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      m_ready = 1'b0;
      chk("rst6_remaining", exp_i.size(), 32'd8);
      rst = 1'b1;
      m_ready = 1'b1;
      exp_i.delete();
      exp_f.delete();
      cur_blk.delete();
      @(negedge clk);
      chk("rst6_m_valid", m_valid_i, 1'b0);
      chk("rst6_s_ready", s_ready_i, 1'b0);
      chk("rst6_m_data", m_data_i, 8'h00);
      @(posedge clk);
      @(negedge clk);
      chk("rst6_m_valid_held", m_valid_i, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst6_no_stale", m_valid_i, 1'b0);
      @(posedge clk);
      #1;
      log_i.delete();
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      wait_empty();
      chk("rst6_count", log_i.size(), 32'd16);
      for (int i = 0; i < 16 && i < log_i.size(); i++) chk("rst6_out", log_i[i], idx_inv[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inv_shiftrow_stream.md
Name: inv_shiftrow_stream

Overview:
Byte-serial AES InvShiftRows stage for the decryption datapath. It accepts a 16-byte AES state one byte per handshake and emits the inverse-row-shifted state one byte per handshake. Two 16-byte banks work as a ping-pong buffer, so one block fills while the previous block drains, giving a sustained rate of 1 byte/cycle. A parameter selects forward ShiftRows instead, so the same block serves the encrypt side.

Parameters:
INVERSE, 1, 1 = InvShiftRows (out[r][c] = in[r][(c-r) mod 4]); 0 = forward ShiftRows (out[r][c] = in[r][(c+r) mod 4])

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
s_valid  input  1  input byte valid
s_ready  output  1  stage can accept an input byte
s_data  input  8  input byte; AES byte order a0..a15 (a0 = state bits [127:120], column-major, index k = 4*c + r)
m_valid  output  1  output byte valid
m_ready  input  1  downstream accepts the output byte
m_data  output  8  output byte, order a0..a15 of the shifted state
m_last  output  1  high with output byte a15

Behaviour:
- Storage: bank[2][16] bytes. Control state: wsel, rsel (1 bit each); wcnt, rcnt (4 bits each); full[1:0].
- Reset (rst high at a clock edge): wsel=rsel=0, wcnt=rcnt=0, full=00. While rst is high, s_ready=0, m_valid=0, m_last=0 and m_data=0. Bank contents are not reset.
- Reset mid-block discards all partial and full blocks. The first byte after reset is a0 of a new block.
- s_ready = !full[wsel] && !rst.
- Write: on s_valid && s_ready, bank[wsel][wcnt] <= s_data and wcnt increments.
  - When wcnt==15, the count wraps to 0, full[wsel] <= 1 and wsel toggles.
- m_valid = full[rsel].
- Read map, INVERSE=1: m_data = bank[rsel][imap(rcnt)], with imap = 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- Read map, INVERSE=0: fmap = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- m_last = m_valid && rcnt==15. When m_valid is low, m_data=0.
- Read: on m_valid && m_ready, rcnt increments.
  - When rcnt==15, the count wraps to 0, full[rsel] <= 0 and rsel toggles.
- Latency: the cycle after byte a15 is accepted, m_valid=1 with output a0. A byte cannot leave before its whole block has arrived.
- Hold: while m_valid && !m_ready, m_data and m_last stay stable. Output is a mux from registered storage; there is no combinational path from s_* to m_*.
- Simultaneous events:
  - Fill-complete on one bank and drain-complete on the other bank in the same cycle both take effect.
  - The write bank is never full and the read bank is never filling, so set and clear never hit the same bank.
- Both banks full: s_ready=0 until the read bank drains its last byte. s_ready rises the cycle after that last output handshake.
- Back-to-back streaming with m_ready held at 1 sustains 1 byte/cycle with no bubbles after the first block.
- s_valid must not depend on s_ready, and m_ready may toggle arbitrarily.

Decomposition:
- Shared package aes_pkg holds:
  - typedef aes_byte_t (8 bits)
  - typedef aes_idx_t (4 bits)
  - constant tables SR_FWD_MAP and SR_INV_MAP (16 x aes_idx_t)
  - function sr_map(idx, inverse), also reusable by the parallel shift-row and key-expansion logic
- No sub-module is needed: bank storage, pointers and the map mux fit in one module of roughly 150 lines.

Test Plan:
1. Inverse, FIPS-197 vector: stream d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, m_ready=1 -> output d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30. m_valid first rises 1 cycle after the 16th input; m_last is high on byte 30.
2. Index pattern, INVERSE=1: input 00..0f -> output 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03. With INVERSE=0, the same input -> 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
3. Streaming: 4 consecutive blocks with s_valid=1 and m_ready=1 -> s_ready never drops after reset, 64 outputs in 64 consecutive cycles starting at cycle 17, every block correct.
4. Backpressure: m_ready=0 while 40 bytes are offered -> exactly 32 accepted, s_ready=0 with full=11. Then m_ready=1 -> s_ready returns the cycle after the 16th output and m_data stays stable during the stall.
5. Random m_ready/s_valid, 1000 blocks -> output matches the sr_map scoreboard with no loss, duplication or reorder.
6. Reset mid-operation: assert rst after 7 input bytes and with one block half-drained -> m_valid=0 and s_ready=0 during reset. The next 16 bytes form a fresh block whose output is correct, with no stale bytes emitted.
